cpeta_adder: RTL and testbench
==============================

CPETA_ADDER -- requirements
Module: cpeta_adder

Interface
REQ-001 Parameter N, default 16, total operand and sum width in bits.
REQ-002 Parameter K, default 9, width of the approximate low segment; legal range 1 <= K <= N-1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  A and B are qualified this cycle.
REQ-006 A  input  N  unsigned operand A.
REQ-007 B  input  N  unsigned operand B.
REQ-008 sum  output  N  registered approximate sum; no carry-out port.
REQ-009 out_valid  output  1  sum holds the result of a qualified operation.

Function
REQ-010 Result SHALL be computed combinationally from the current A and B, then registered: one-cycle latency from the sampling edge to the sum/out_valid update.
REQ-011 On each rising edge with in_valid=1, sum SHALL load the approximate sum of A and B, and out_valid SHALL be set to 1.
REQ-012 On each rising edge with in_valid=0, sum SHALL hold its value and out_valid SHALL be cleared to 0.
REQ-013 Low segment, bits K-1..0, is the carry-free error-tolerant part, processed by scanning from bit K-1 down to bit 0.
REQ-014 Before the first position where A[i]=B[i]=1, sum[i] SHALL be A[i] XOR B[i].
REQ-015 At the first such position and at every lower bit, sum[i] SHALL be 1.
REQ-016 If no such position exists, the low segment SHALL be A XOR B.
REQ-017 Carry prediction: the carry into the high segment SHALL be cin = A[K-1] AND B[K-1]; no other low-segment carry is propagated.
REQ-018 High segment, bits N-1..K, SHALL be the exact sum A[N-1:K] + B[N-1:K] + cin, truncated modulo 2^(N-K).
REQ-019 High-segment overflow SHALL be discarded silently: no flag and no saturation.
REQ-020 The design SHALL be purely combinational between the input pins and the sum register: no input registers and no multi-cycle paths.
REQ-021 The low-segment scan SHALL be implemented as a parameterised prefix "seen-both-ones" chain, so that any legal N and K synthesises.
REQ-022 Back-to-back in_valid=1 cycles SHALL each produce a result on the following cycle, giving a throughput of one result per clock.

Reset
REQ-023 While rst_n=0, sum SHALL be all zeros and out_valid SHALL be 0, asynchronously, regardless of clk.
REQ-024 Deassertion of rst_n is synchronised externally; the first capture SHALL occur on the first rising edge with rst_n=1 and in_valid=1.
REQ-025 Asserting reset mid-stream SHALL discard any pending result; no result from before reset SHALL appear afterwards.

Verification (N=16, K=9, in_valid=1, check sum one cycle later)
REQ-026 A=0x1234, B=0x5678 -> sum=0x687F.
- Low segment: 0x07F, with the first both-ones position at bit 5.
- Carry-in: cin=0.
- High segment: 0x09 + 0x2B = 0x34.
REQ-027 Each of the following -> sum=0xFFFF:
- A=0xFFFF, B=0x0001 (both-ones position at bit 0).
- A=0xAAAA, B=0x5555 (disjoint bits).
- A=0x0F0F, B=0xF0F0 (disjoint bits).
REQ-028 A=0x0100, B=0x0100 -> sum=0x03FF: the low segment is all ones from bit 8, cin=1, and the high segment is 0x001.
REQ-029 Overflow wrap: A=0xFE00, B=0x0200 -> sum=0x0000; the high segment 0x7F+0x01 wraps to 0 and the low segment is 0.
REQ-030 Control behaviour:
- A=B=0 -> sum=0x0000.
- in_valid=0 for one cycle -> sum is held and out_valid=0.
- rst_n pulsed low between clock edges -> sum=0 and out_valid=0 immediately.
- Repeating A=0x1234, B=0x5678 after reset -> sum=0x687F again.

Source files
------------

// File: rtl/cpeta_adder.sv
// -----------------------------------------------------------------------------
// cpeta_adder
//   Registered approximate adder. The sum is split into two segments:
//     - low segment [K-1:0]: carry-free error-tolerant part. Scanning from
//       bit K-1 down to bit 0, bits are A^B until the first position where
//       both operands are 1. That position and every lower bit become 1.
//     - high segment [N-1:K]: exact A+B of the upper bits, plus a predicted
//       carry cin = A[K-1] & B[K-1]. Overflow wraps silently.
//   The result is formed combinationally from A/B and captured on the rising
//   edge when in_valid is high (one-cycle latency, one result per clock).
//
// Ports
//   clk        clock, rising-edge active
//   rst_n      asynchronous active-low reset (clears sum and out_valid)
//   in_valid   A and B are qualified this cycle
//   A, B       N-bit unsigned operands
//   sum        registered N-bit approximate sum (no carry-out)
//   out_valid  sum holds a result captured on the previous edge
// -----------------------------------------------------------------------------
module cpeta_adder #(
  parameter int N = 16,
  parameter int K = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] sum,
  output logic         out_valid
);

  // seen_both[i] is high when some bit j >= i in the low segment has
  // A[j] = B[j] = 1. seen_both[K] is the empty prefix above the segment.
  logic [K:0]       seen_both;
  logic [K-1:0]     low_next;
  logic [N-K-1:0]   high_next;
  logic             cin;
  logic [N-1:0]     sum_next;
  logic [N-1:0]     sum_reg;
  logic             out_valid_reg;

  assign seen_both[K] = 1'b0;

  generate
    for (genvar gi = K - 1; gi >= 0; gi--) begin : g_low
      assign seen_both[gi] = seen_both[gi+1] | (A[gi] & B[gi]);
      // Once a both-ones bit has been seen (inclusive), force the bit high.
      assign low_next[gi]  = seen_both[gi] ? 1'b1 : (A[gi] ^ B[gi]);
    end
  endgenerate

  // Carry predicted only from the top bit of the low segment.
  assign cin       = A[K-1] & B[K-1];
  // Addition is sized to the high segment so the overflow bit drops out.
  assign high_next = A[N-1:K] + B[N-1:K] + {{(N-K-1){1'b0}}, cin};
  assign sum_next  = {high_next, low_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg <= sum_next;
      end
    end
  end

  assign sum       = sum_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_cpeta_adder.sv
// -----------------------------------------------------------------------------
// tb_cpeta_adder
//   Directed checks of cpeta_adder at N=16, K=9 with hand-computed results.
// -----------------------------------------------------------------------------
module tb_cpeta_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] sum;
  logic        out_valid;

  int vectors;
  int miscompares;

  cpeta_adder #(.N(16), .K(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("check %-14s observed %b expected %b", tag, obs, exp);
  endtask

  // Present A/B with in_valid=1 on the falling edge, then check right after
  // the following rising edge.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
    @(negedge clk);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check16(tag, sum, exp);
    check1({tag, "_v"}, out_valid, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    A           = 16'h0000;
    B           = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check16("rst_sum", sum, 16'h0000);
    check1("rst_valid", out_valid, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check1("idle_valid", out_valid, 1'b0);

    // Main function, back-to-back
    apply("basic",     16'h1234, 16'h5678, 16'h687F);
    apply("ff_01",     16'hFFFF, 16'h0001, 16'hFFFF);
    apply("aa_55",     16'hAAAA, 16'h5555, 16'hFFFF);
    apply("0f_f0",     16'h0F0F, 16'hF0F0, 16'hFFFF);
    apply("cin",       16'h0100, 16'h0100, 16'h03FF);
    apply("wrap",      16'hFE00, 16'h0200, 16'h0000);
    apply("small",     16'h0003, 16'h0001, 16'h0003);
    apply("disjoint",  16'h0004, 16'h0002, 16'h0006);
    apply("hi_wrap",   16'h8000, 16'h8000, 16'h0000);
    apply("zero",      16'h0000, 16'h0000, 16'h0000);
    apply("basic2",    16'h1234, 16'h5678, 16'h687F);

    // Hold with in_valid=0: inputs change but must be ignored
    @(negedge clk);
    in_valid = 1'b0;
    A        = 16'hFFFF;
    B        = 16'hFFFF;
    @(posedge clk);
    #1;
    check16("hold_sum", sum, 16'h687F);
    check1("hold_valid", out_valid, 1'b0);

    // Mid-stream reset between edges, with a qualified operation pending
    apply("pre_rst",   16'h0100, 16'h0100, 16'h03FF);
    @(negedge clk);
    A        = 16'h1234;
    B        = 16'h5678;
    in_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check16("arst_sum", sum, 16'h0000);
    check1("arst_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check16("in_rst_sum", sum, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check16("post_rst_sum", sum, 16'h0000);
    check1("post_rst_val", out_valid, 1'b0);

    apply("after_rst", 16'h1234, 16'h5678, 16'h687F);

    @(negedge clk);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
